// File: rtl/echo_mixer_pkg.sv
// Shared types and constants for the echo mixer: sample width, wet-gain
// range and the fade-in state machine encoding.
package echo_mixer_pkg;

  localparam int SAMPLE_W = 10;
  localparam int GAIN_W   = 4;

  // Full wet gain, expressed in eighths (8/8 = unity).
  localparam logic [GAIN_W-1:0] GAIN_MAX = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_add_offset.sv
// Signed dry+wet sum with saturation to the sample range, followed by the
// DAC offset so the result is an offset-binary code.  Purely combinational;
// the caller registers the output.
module sat_add_offset
  import echo_mixer_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] DAC_OFFSET = 10'h200
) (
  input  logic signed [SAMPLE_W-1:0] a,
  input  logic signed [SAMPLE_W-1:0] b,
  output logic        [SAMPLE_W-1:0] y
);

  // Two guard bits so the sum of two full-scale samples cannot wrap.
  localparam logic signed [SAMPLE_W+1:0] MAX_V = {3'b000, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W+1:0] MIN_V = {3'b111, {(SAMPLE_W-1){1'b0}}};

  logic signed [SAMPLE_W+1:0] sum;
  logic signed [SAMPLE_W-1:0] sat;

  // Widen, add, clamp to the rails, then shift into offset-binary (wraps mod 2^W).
  always_comb begin
    sum = {{2{a[SAMPLE_W-1]}}, a} + {{2{b[SAMPLE_W-1]}}, b};
    if (sum > MAX_V) begin
      sat = MAX_V[SAMPLE_W-1:0];
    end else if (sum < MIN_V) begin
      sat = MIN_V[SAMPLE_W-1:0];
    end else begin
      sat = sum[SAMPLE_W-1:0];
    end
    y = sat + DAC_OFFSET;
  end

endmodule

// File: rtl/echo_mixer.sv
// Echo mixer: fades the delayed (wet) path in over eight gain steps once the
// delay line is producing valid data, and mixes it with the dry input into a
// saturated offset-binary DAC code.  Two-stage pipeline: stage 1 scales the
// wet sample, stage 2 adds, saturates and offsets.
module echo_mixer
  import echo_mixer_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] DAC_OFFSET       = 10'h200,
  parameter int                  RAMP_STEP_CYCLES = 1024,
  parameter int                  WET_SHIFT        = 1
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] x,
  input  logic [SAMPLE_W-1:0] delayed,
  input  logic                wet_valid,
  output logic [SAMPLE_W-1:0] data_out,
  output logic [GAIN_W-1:0]   gain,
  output logic                ramp_done,
  output state_t              state_dbg
);

  localparam logic [15:0] STEP_LAST = 16'(RAMP_STEP_CYCLES - 1);

  state_t              state, state_nx;
  logic [GAIN_W-1:0]   gain_nx;
  logic [15:0]         cnt, cnt_nx;
  logic                done_nx;

  logic signed [13:0]         d_ext, g_ext, prod;
  logic signed [SAMPLE_W-1:0] wet_nx;
  logic signed [SAMPLE_W-1:0] dry_r, wet_r;
  logic        [SAMPLE_W-1:0] mix;

  assign state_dbg = state;

  // Fade-in state, step counter, gain and ramp_done registers.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      gain      <= '0;
      ramp_done <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      gain      <= gain_nx;
      ramp_done <= done_nx;
    end
  end

  // Next-state logic: losing wet_valid always drops back to IDLE with zero
  // gain, even on a cycle where a gain step would otherwise happen.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gain_nx  = gain;
    case (state)
      IDLE: begin
        cnt_nx  = '0;
        gain_nx = '0;
        if (wet_valid) state_nx = RAMP;
      end
      RAMP: begin
        if (!wet_valid) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          gain_nx  = '0;
        end else if (cnt == STEP_LAST) begin
          cnt_nx  = '0;
          gain_nx = gain + 4'd1;
          if (gain_nx == GAIN_MAX) state_nx = RUN;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      RUN: begin
        cnt_nx  = '0;
        gain_nx = GAIN_MAX;
        if (!wet_valid) begin
          state_nx = IDLE;
          gain_nx  = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        gain_nx  = '0;
      end
    endcase
    done_nx = (state_nx == RUN);
  end

  // Wet scaling: delayed * gain/8, plus the extra wet attenuation, floored.
  assign d_ext  = {{4{delayed[SAMPLE_W-1]}}, delayed};
  assign g_ext  = {10'd0, gain};
  assign prod   = d_ext * g_ext;
  assign wet_nx = SAMPLE_W'(prod >>> (3 + WET_SHIFT));

  // Stage 1: register dry sample and scaled wet sample together.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      dry_r <= '0;
      wet_r <= '0;
    end else begin
      dry_r <= x;
      wet_r <= wet_nx;
    end
  end

  sat_add_offset #(
    .DAC_OFFSET(DAC_OFFSET)
  ) u_sat_add_offset (
    .a(dry_r),
    .b(wet_r),
    .y(mix)
  );

  // Stage 2: register the saturated, offset mix as the DAC code.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      data_out <= DAC_OFFSET;
    end else begin
      data_out <= mix;
    end
  end

endmodule

// File: tb/tb_echo_mixer.sv
// Bench for echo_mixer: two instances with different ramp/shift parameters
// share one stimulus stream and are compared every clock to a reference
// model built from the fade-in rule and plain integer arithmetic.
module tb_echo_mixer;
  import echo_mixer_pkg::*;

  localparam int RSC_A = 4;
  localparam int WS_A  = 1;
  localparam int RSC_B = 2;
  localparam int WS_B  = 0;
  localparam logic [9:0] OFFSET = 10'h200;

  // ---------------- clock / reset ----------------
  logic sysclk = 1'b0;
  logic rst;
  always #5 sysclk = ~sysclk;

  logic [9:0] x, delayed;
  logic       wet_valid;

  logic [9:0] data_out_a, data_out_b;
  logic [3:0] gain_a, gain_b;
  logic       ramp_done_a, ramp_done_b;
  state_t     state_dbg_a, state_dbg_b;

  echo_mixer #(
    .DAC_OFFSET(OFFSET), .RAMP_STEP_CYCLES(RSC_A), .WET_SHIFT(WS_A)
  ) dut_a (
    .sysclk(sysclk), .rst(rst), .x(x), .delayed(delayed), .wet_valid(wet_valid),
    .data_out(data_out_a), .gain(gain_a), .ramp_done(ramp_done_a),
    .state_dbg(state_dbg_a)
  );

  echo_mixer #(
    .DAC_OFFSET(OFFSET), .RAMP_STEP_CYCLES(RSC_B), .WET_SHIFT(WS_B)
  ) dut_b (
    .sysclk(sysclk), .rst(rst), .x(x), .delayed(delayed), .wet_valid(wet_valid),
    .data_out(data_out_b), .gain(gain_b), .ramp_done(ramp_done_b),
    .state_dbg(state_dbg_b)
  );

  // ---------------- reference model ----------------
  // k = number of consecutive clock edges that sampled wet_valid=1.
  int k;
  logic [9:0] exp_qa[$];
  logic [9:0] exp_qb[$];
  int checks = 0;
  int errors = 0;

  // Gain after k valid edges: first edge enters the ramp at 0, then one
  // step every rsc edges, capped at 8.
  function automatic int model_gain(int kv, int rsc);
    int g;
    if (kv == 0) return 0;
    g = (kv - 1) / rsc;
    return (g > 8) ? 8 : g;
  endfunction

  function automatic logic [9:0] model_mix(logic [9:0] xv, logic [9:0] dv, int g, int ws);
    int xs;
    int ds;
    int wet;
    int s;
    xs  = $signed(xv);
    ds  = $signed(dv);
    wet = (ds * g) >>> (3 + ws);
    s   = xs + wet;
    if (s > 511)  s = 511;
    if (s < -512) s = -512;
    return 10'((s + 512) & 1023);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(string tag, logic [15:0] obs, logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_data_a", 16'(data_out_a), 16'(OFFSET));
    chk("rst_data_b", 16'(data_out_b), 16'(OFFSET));
    chk("rst_gain_a", 16'(gain_a), 16'd0);
    chk("rst_gain_b", 16'(gain_b), 16'd0);
    chk("rst_done_a", 16'(ramp_done_a), 16'd0);
    chk("rst_done_b", 16'(ramp_done_b), 16'd0);
    chk("rst_state_a", 16'(state_dbg_a), 16'(IDLE));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: predict, clock, then compare all outputs 1 ns after the edge.
  task automatic step();
    int ga;
    int gb;
    ga = model_gain(k, RSC_A);
    gb = model_gain(k, RSC_B);
    exp_qa.push_back(model_mix(x, delayed, ga, WS_A));
    exp_qb.push_back(model_mix(x, delayed, gb, WS_B));
    @(posedge sysclk);
    k = wet_valid ? k + 1 : 0;
    #1;
    ga = model_gain(k, RSC_A);
    gb = model_gain(k, RSC_B);
    chk("data_a", 16'(data_out_a), 16'(exp_qa.pop_front()));
    chk("data_b", 16'(data_out_b), 16'(exp_qb.pop_front()));
    chk("gain_a", 16'(gain_a), 16'(ga));
    chk("gain_b", 16'(gain_b), 16'(gb));
    chk("done_a", 16'(ramp_done_a), 16'(ga == 8));
    chk("done_b", 16'(ramp_done_b), 16'(gb == 8));
  endtask

  // Assert reset between edges (checks the asynchronous effect at once),
  // hold for two edges, release on a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_reset_vals();
    k = 0;
    exp_qa = {};
    exp_qb = {};
    exp_qa.push_back(OFFSET);
    exp_qb.push_back(OFFSET);
    repeat (2) begin
      @(posedge sysclk);
      #1;
      chk_reset_vals();
    end
    @(negedge sysclk);
    rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst       = 1'b1;
    x         = 10'h155;
    delayed   = 10'h155;
    wet_valid = 1'b0;
    k         = 0;
    #3;
    do_reset();
    step();
    chk("post_rst_data_a", 16'(data_out_a), 16'(OFFSET));
    step();

    // Dry-only path: gain 0 passes x through with the offset.
    x = 10'd100; delayed = 10'd300; wet_valid = 1'b0;
    repeat (3) step();
    chk("dry_only_a", 16'(data_out_a), 16'h264);
    chk("dry_only_b", 16'(data_out_b), 16'h264);

    // Full fade-in with a constant wet sample.
    x = 10'd0; delayed = 10'd256; wet_valid = 1'b1;
    repeat (40) step();
    chk("ramp_final_a", 16'(data_out_a), 16'h280);
    chk("ramp_done_final_a", 16'(ramp_done_a), 16'd1);
    chk("ramp_state_a", 16'(state_dbg_a), 16'(RUN));

    // Saturation at both rails with unity wet gain and no extra shift.
    x = 10'd500; delayed = 10'd511;
    repeat (2) step();
    chk("sat_hi_b", 16'(data_out_b), 16'h3FF);
    x = 10'h200; delayed = 10'h200;
    repeat (2) step();
    chk("sat_lo_b", 16'(data_out_b), 16'h000);

    // Drop wet_valid exactly on a step boundary, then restart the ramp.
    wet_valid = 1'b0;
    step();
    wet_valid = 1'b1;
    repeat (8) step();
    chk("boundary_gain_a", 16'(gain_a), 16'd1);
    wet_valid = 1'b0;
    step();
    chk("drop_gain_a", 16'(gain_a), 16'd0);
    chk("drop_state_a", 16'(state_dbg_a), 16'(IDLE));
    wet_valid = 1'b1;
    repeat (6) step();
    chk("restart_gain_a", 16'(gain_a), 16'd1);

    // Randomized samples with occasional wet_valid drops.
    for (int i = 0; i < 300; i++) begin
      x         = 10'($urandom_range(0, 1023));
      delayed   = 10'($urandom_range(0, 1023));
      wet_valid = ($urandom_range(0, 31) != 0);
      step();
    end

    // Reset while fully ramped up.
    wet_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      x       = 10'($urandom_range(0, 1023));
      delayed = 10'($urandom_range(0, 1023));
      step();
    end
    chk("pre_rst_done_a", 16'(ramp_done_a), 16'd1);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      x       = 10'($urandom_range(0, 1023));
      delayed = 10'($urandom_range(0, 1023));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
